// File: rtl/as6d_vp_buffer_rd_ctrl.sv
// Burst read sequencer for the vp_buffer ECC RAM wrapper: issues CSB/REB/AB strobes,
// returns QB through a credit-protected FWFT skid FIFO, and counts ECC events.
module as6d_vp_buffer_rd_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 128,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH:0]   req_len,
  output logic                  ram_csb,
  output logic                  ram_reb,
  output logic [ADDR_WIDTH-1:0] ram_ab,
  input  logic [DATA_WIDTH-1:0] ram_qb,
  input  logic                  ram_sbit_err,
  input  logic                  ram_dbit_err,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_last,
  output logic                  dout_derr,
  output logic                  done,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_ab;
  logic [ADDR_WIDTH:0]   r_rem;
  logic [RD_LAT:0]       r_vld_pipe;
  logic [RD_LAT:0]       r_last_pipe;
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_fcnt;
  logic [CNT_WIDTH-1:0]  r_scnt, r_dcnt;

  logic       w_push, w_pop, w_issue, w_credit;
  logic [7:0] w_inflight;
  logic [EW-1:0] w_head;

  assign w_push = r_vld_pipe[RD_LAT];
  assign w_pop  = dout_valid && dout_ready;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) w_inflight = w_inflight + 8'(r_vld_pipe[i]);
  end

  // A pop this cycle frees a slot before the new strobe can land, which keeps
  // one strobe per cycle sustainable with dout_ready high.
  assign w_credit = (8'(r_fcnt) + w_inflight - 8'(w_pop)) < 8'(FIFO_DEPTH);
  assign w_issue  = (r_state == S_ISSUE) && w_credit && (r_rem != '0);

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_ab        <= '0;
      r_rem       <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[RD_LAT-1:0], w_issue};
      r_last_pipe <= {r_last_pipe[RD_LAT-1:0], w_issue && (r_rem == LEN_ONE)};
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_addr  <= req_addr;
          r_rem   <= req_len;
          r_state <= (req_len == '0) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: if (w_issue) begin
          r_ab   <= r_addr;
          r_addr <= r_addr + ADDR_ONE;
          r_rem  <= r_rem - LEN_ONE;
          if (r_rem == LEN_ONE) r_state <= S_DRAIN;
        end
        S_DRAIN: if (w_pop && dout_last) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);
  assign ram_csb   = r_vld_pipe[0];
  assign ram_reb   = r_vld_pipe[0];
  assign ram_ab    = r_ab;

  always_ff @(posedge r_clk) begin
    if (w_push) r_mem[r_wptr] <= {ram_qb, ram_dbit_err, r_last_pipe[RD_LAT]};
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  assign w_head     = r_mem[r_rptr];
  assign dout_valid = (r_fcnt != '0);
  assign dout_data  = dout_valid ? w_head[EW-1:2] : '0;
  assign dout_derr  = dout_valid & w_head[1];
  assign dout_last  = dout_valid & w_head[0];

  // ECC flags only mean something on tap cycles, when a requested beat is at QB.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_scnt <= '0;
      r_dcnt <= '0;
    end else if (err_clr) begin
      r_scnt <= CNT_WIDTH'(w_push && ram_sbit_err);
      r_dcnt <= CNT_WIDTH'(w_push && ram_dbit_err);
    end else begin
      if (w_push && ram_sbit_err && (r_scnt != '1)) r_scnt <= r_scnt + CNT_ONE;
      if (w_push && ram_dbit_err && (r_dcnt != '1)) r_dcnt <= r_dcnt + CNT_ONE;
    end
  end

  assign sbit_cnt = r_scnt;
  assign dbit_cnt = r_dcnt;

  always_ff @(posedge r_clk) begin
    if (!r_rst) assert (!(w_push && !w_pop && (r_fcnt == CW'(FIFO_DEPTH))));
  end

endmodule

// File: tb/tb_as6d_vp_buffer_rd_ctrl.sv
// Directed bench for as6d_vp_buffer_rd_ctrl with a behavioural RD_LAT=2 RAM wrapper model.
module tb_as6d_vp_buffer_rd_ctrl;
  localparam int AW = 12;
  localparam int DW = 128;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [AW:0]   req_len = '0;
  logic          ram_csb, ram_reb;
  logic [AW-1:0] ram_ab;
  logic [DW-1:0] ram_qb;
  logic          ram_sbit_err, ram_dbit_err;
  logic          dout_valid, dout_ready = 1'b1;
  logic [DW-1:0] dout_data;
  logic          dout_last, dout_derr, done;
  logic          err_clr = 1'b0;
  logic [15:0]   sbit_cnt, dbit_cnt;

  always #5 r_clk = ~r_clk;

  as6d_vp_buffer_rd_ctrl dut (
    .r_clk(r_clk), .r_rst(r_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .ram_csb(ram_csb), .ram_reb(ram_reb), .ram_ab(ram_ab), .ram_qb(ram_qb),
    .ram_sbit_err(ram_sbit_err), .ram_dbit_err(ram_dbit_err),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last), .dout_derr(dout_derr), .done(done),
    .err_clr(err_clr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt)
  );

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return {8{4'hA, a}};
  endfunction

  // RAM wrapper model: strobe seen in cycle s, QB/ERR valid in cycle s+2
  logic          m_v1 = 1'b0, m_sb = 1'b0, m_db = 1'b0;
  logic [AW-1:0] m_a1 = '0, m_qa = '0;
  logic [DW-1:0] m_q = '0;
  bit            sb_mask [4096];
  bit            db_mask [4096];
  logic          spur_s = 1'b0, spur_d = 1'b0;

  always @(posedge r_clk) begin
    m_v1 <= ram_csb && ram_reb;
    m_a1 <= ram_ab;
    m_q  <= dat(m_a1);
    m_qa <= m_a1;
    m_sb <= m_v1 && sb_mask[m_a1];
    m_db <= m_v1 && db_mask[m_a1];
  end
  assign ram_qb       = m_q;
  assign ram_sbit_err = m_sb | spur_s;
  assign ram_dbit_err = m_db | spur_d;

  int cyc = 0;
  always @(posedge r_clk) cyc <= cyc + 1;

  logic [AW-1:0]   ab_q[$];
  int              ab_cyc[$];
  logic [DW+1:0]   beat_q[$];
  int n_iss, n_acc, max_out, n_done, done_cyc, last_acc_cyc, req_cyc;
  bit done_seen;

  always @(negedge r_clk) begin
    if (ram_csb) begin ab_q.push_back(ram_ab); ab_cyc.push_back(cyc); n_iss++; end
    if (dout_valid && dout_ready) begin
      beat_q.push_back({dout_derr, dout_last, dout_data}); n_acc++; last_acc_cyc = cyc;
    end
    if (done) begin done_seen = 1'b1; done_cyc = cyc; n_done++; end
    if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [135:0] act, input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge r_clk); #1;
  endtask

  bit            clr_arm = 1'b0;
  logic [AW-1:0] clr_addr = '0;

  task automatic do_burst(input logic [AW-1:0] a, input logic [AW:0] len, input int slo, input int shi);
    ab_q.delete(); ab_cyc.delete(); beat_q.delete();
    n_iss = 0; n_acc = 0; max_out = 0; n_done = 0; done_seen = 1'b0;
    req_valid = 1'b1; req_addr = a; req_len = len; req_cyc = cyc;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (k == slo) dout_ready = 1'b0;
      if (k == shi) dout_ready = 1'b1;
      step();
      err_clr = clr_arm && ram_sbit_err && (m_qa == clr_addr);
      if (done_seen) break;
    end
    err_clr = 1'b0; dout_ready = 1'b1;
    chk("done_seen", done_seen, 1);
  endtask

  task automatic check_burst(input string t, input logic [AW-1:0] a, input int len, input int derr_i);
    chk({t, "_nbeats"}, beat_q.size(), len);
    chk({t, "_nstrobe"}, ab_q.size(), len);
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] ea;
      ea = a + AW'(i);
      if (i < beat_q.size())
        chk($sformatf("%s_beat%0d", t, i), beat_q[i], {(i == derr_i), (i == len - 1), dat(ea)});
      if (i < ab_q.size()) chk($sformatf("%s_ab%0d", t, i), ab_q[i], ea);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_req_ready"}, req_ready, 1);
    chk({t, "_outs"}, {dout_valid, dout_last, dout_derr, done, ram_csb, ram_reb}, 0);
    chk({t, "_ab"}, ram_ab, 0);
    chk({t, "_data"}, dout_data, 0);
    chk({t, "_cnts"}, {sbit_cnt, dbit_cnt}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk_reset("rst");
    r_rst = 1'b0;
    step();

    // 1: plain burst, full throughput
    do_burst(12'h010, 8, 0, 0);
    check_burst("t1", 12'h010, 8, -1);
    if (ab_cyc.size() == 8) chk("t1_consec", ab_cyc[7] - ab_cyc[0], 7);
    chk("t1_done_lat", done_cyc, last_acc_cyc + 1);
    chk("t1_done_once", n_done, 1);

    // 2: address wrap
    do_burst(12'hFFE, 4, 0, 0);
    check_burst("t2", 12'hFFE, 4, -1);

    // 3: backpressure, credits bound outstanding beats
    do_burst(12'h040, 16, 3, 21);
    check_burst("t3", 12'h040, 16, -1);
    chk("t3_credit", max_out <= 4, 1);
    if (ab_cyc.size() == 16) chk("t3_stalled", ab_cyc[15] - ab_cyc[0] > 15, 1);

    // 4: spurious flags while idle are ignored; tagged beats counted
    spur_s = 1'b1; spur_d = 1'b1;
    step(); step();
    spur_s = 1'b0; spur_d = 1'b0;
    chk("t4_spur", {sbit_cnt, dbit_cnt}, 0);
    sb_mask[12'h021] = 1'b1; db_mask[12'h024] = 1'b1;
    do_burst(12'h020, 8, 0, 0);
    check_burst("t4", 12'h020, 8, 4);
    chk("t4_sbit", sbit_cnt, 1);
    chk("t4_dbit", dbit_cnt, 1);
    sb_mask[12'h021] = 1'b0; db_mask[12'h024] = 1'b0;

    // 5: reset while draining
    dout_ready = 1'b0;
    req_valid = 1'b1; req_addr = 12'h300; req_len = 2;
    step();
    req_valid = 1'b0;
    repeat (6) step();
    chk("t5_buffered", dout_valid, 1);
    r_rst = 1'b1;
    step();
    chk_reset("t5_rst");
    r_rst = 1'b0; dout_ready = 1'b1;
    step(); step();
    chk("t5_empty", dout_valid, 0);
    do_burst(12'h100, 2, 0, 0);
    check_burst("t5", 12'h100, 2, -1);

    // 6: zero-length request
    do_burst(12'h123, 0, 0, 0);
    chk("t6_nostrobe", n_iss, 0);
    chk("t6_done_lat", done_cyc, req_cyc + 1);
    chk("t6_done_once", n_done, 1);

    // 6b: err_clr coincident with the third sbit event leaves the count at 1
    sb_mask[12'h200] = 1'b1; sb_mask[12'h201] = 1'b1; sb_mask[12'h202] = 1'b1;
    clr_arm = 1'b1; clr_addr = 12'h202;
    do_burst(12'h200, 3, 0, 0);
    clr_arm = 1'b0;
    check_burst("t6b", 12'h200, 3, -1);
    chk("t6b_sbit", sbit_cnt, 1);
    chk("t6b_dbit", dbit_cnt, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t6b_clr", sbit_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
